// File: rtl/wb_bfm_pkg.sv
// Shared Wishbone BFM definitions: cycle/burst type encodings and the arbiter state enum.
package wb_bfm_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_bfm_rr_sel.sv
// Combinational round-robin selector: picks the first requester after index `last`,
// wrapping modulo NUM_REQ, and returns it one-hot and encoded.
module wb_bfm_rr_sel #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        grant = '0;
        idx   = last;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/wb_bfm_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one slave port between NUM_MASTERS masters.
// Define WB_BFM_ARBITER_TIMEOUT_EN to build the stalled-access watchdog.
module wb_bfm_arbiter
    import wb_bfm_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 256
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
    input  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]        wbm_we_i,
    input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
    output logic [NUM_MASTERS*DW-1:0]     wbm_dat_o,
    output logic [NUM_MASTERS-1:0]        wbm_ack_o,
    output logic [NUM_MASTERS-1:0]        wbm_err_o,
    output logic [NUM_MASTERS-1:0]        wbm_rty_o,
    output logic [AW-1:0]                 wbs_adr_o,
    output logic [DW-1:0]                 wbs_dat_o,
    output logic [DW/8-1:0]               wbs_sel_o,
    output logic                          wbs_we_o,
    output logic                          wbs_cyc_o,
    output logic                          wbs_stb_o,
    output logic [2:0]                    wbs_cti_o,
    output logic [1:0]                    wbs_bte_o,
    input  logic [DW-1:0]                 wbs_dat_i,
    input  logic                          wbs_ack_i,
    input  logic                          wbs_err_i,
    input  logic                          wbs_rty_i,
    output logic [NUM_MASTERS-1:0]        grant_o
);

    localparam int LW = $clog2(NUM_MASTERS);
    localparam int SW = DW / 8;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TIMEOUT < 1 || (DW % 8) != 0) begin : g_bad_params
        $error("wb_bfm_arbiter: unsupported parameter set");
    end

    arb_state_e           state;
    logic [NUM_MASTERS-1:0] grant;
    logic [LW-1:0]        last;
    logic [NUM_MASTERS-1:0] sel_grant;
    logic [LW-1:0]        sel_idx;
    logic                 busy;
    logic                 cur_cyc;
    logic                 cur_stb;
    logic                 wd_hit;
    logic [NUM_MASTERS-1:0] fwd;

    logic [AW-1:0] adr_m [NUM_MASTERS];
    logic [DW-1:0] dat_m [NUM_MASTERS];
    logic [SW-1:0] sel_m [NUM_MASTERS];
    logic [2:0]    cti_m [NUM_MASTERS];
    logic [1:0]    bte_m [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign adr_m[i] = wbm_adr_i[i*AW +: AW];
        assign dat_m[i] = wbm_dat_i[i*DW +: DW];
        assign sel_m[i] = wbm_sel_i[i*SW +: SW];
        assign cti_m[i] = wbm_cti_i[i*3 +: 3];
        assign bte_m[i] = wbm_bte_i[i*2 +: 2];
    end

    wb_bfm_rr_sel #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (LW)
    ) u_rr_sel (
        .req   (wbm_cyc_i),
        .last  (last),
        .grant (sel_grant),
        .idx   (sel_idx)
    );

    // In BUSY `last` is the granted index, so it doubles as the mux select.
    assign busy    = (state == BUSY);
    assign cur_cyc = wbm_cyc_i[last];
    assign cur_stb = wbm_stb_i[last];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            grant <= '0;
            last  <= LW'(NUM_MASTERS - 1);
        end else begin
            case (state)
                IDLE: if (|wbm_cyc_i) begin
                    grant <= sel_grant;
                    last  <= sel_idx;
                    state <= BUSY;
                end
                BUSY: if (!cur_cyc) begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_BFM_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;

    assign wd_hit = busy && (wd_cnt == CW'(TIMEOUT));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wd_cnt <= '0;
        end else if (!busy || !cur_stb || wbs_ack_i || wbs_err_i || wbs_rty_i || wd_hit) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    assign wbs_cyc_o = busy & cur_cyc;
    assign wbs_stb_o = busy & cur_stb & ~wd_hit;
    assign wbs_adr_o = adr_m[last];
    assign wbs_dat_o = dat_m[last];
    assign wbs_sel_o = sel_m[last];
    assign wbs_we_o  = wbm_we_i[last];
    assign wbs_cti_o = cti_m[last];
    assign wbs_bte_o = bte_m[last];

    // A master that has already dropped cyc must not see a late response.
    assign fwd       = grant & wbm_cyc_i;
    assign wbm_ack_o = fwd & {NUM_MASTERS{wbs_ack_i}};
    assign wbm_err_o = fwd & {NUM_MASTERS{wbs_err_i | wd_hit}};
    assign wbm_rty_o = fwd & {NUM_MASTERS{wbs_rty_i}};
    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
    assign grant_o   = grant;

endmodule

// File: tb/tb_wb_bfm_arbiter.sv
// Self-checking bench for wb_bfm_arbiter: random multi-master traffic against a memory slave,
// checked cycle by cycle against a behavioural round-robin ownership model.
module tb_wb_bfm_arbiter;
    import wb_bfm_pkg::*;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NM*AW-1:0] wbm_adr_i;
    logic [NM*DW-1:0] wbm_dat_i;
    logic [NM*SW-1:0] wbm_sel_i;
    logic [NM-1:0]    wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [NM*3-1:0]  wbm_cti_i;
    logic [NM*2-1:0]  wbm_bte_i;
    logic [NM*DW-1:0] wbm_dat_o;
    logic [NM-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
    logic [AW-1:0]    wbs_adr_o;
    logic [DW-1:0]    wbs_dat_o, wbs_dat_i;
    logic [SW-1:0]    wbs_sel_o;
    logic             wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]       wbs_cti_o;
    logic [1:0]       wbs_bte_o;
    logic             wbs_ack_i, wbs_err_i, wbs_rty_i;

    logic [NM-1:0] m_cyc = '0, m_stb = '0, m_we = '0;
    logic [AW-1:0] m_adr [NM];
    logic [DW-1:0] m_dat [NM];
    logic [SW-1:0] m_sel [NM];
    logic [2:0]    m_cti [NM];
    logic [1:0]    m_bte [NM];

    int vectors = 0;
    int miscompares = 0;

    wb_bfm_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
        for (int i = 0; i < NM; i++) begin
            wbm_adr_i[i*AW +: AW] = m_adr[i];
            wbm_dat_i[i*DW +: DW] = m_dat[i];
            wbm_sel_i[i*SW +: SW] = m_sel[i];
            wbm_cti_i[i*3 +: 3]   = m_cti[i];
            wbm_bte_i[i*2 +: 2]   = m_bte[i];
        end
        wbm_cyc_i = m_cyc;
        wbm_stb_i = m_stb;
        wbm_we_i  = m_we;
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory slave with random wait states and occasional error responses
    logic [DW-1:0] mem [256];
    logic [DW-1:0] exp_mem [256];
    logic s_ready = 1'b1, s_err_en = 1'b0, s_hang = 1'b0, rand_slave = 1'b0;

    assign wbs_ack_i = wbs_cyc_o & wbs_stb_o & s_ready & ~s_hang & ~s_err_en;
    assign wbs_err_i = wbs_cyc_o & wbs_stb_o & s_ready & ~s_hang & s_err_en;
    assign wbs_rty_i = 1'b0;
    assign wbs_dat_i = mem[wbs_adr_o[9:2]];

    always @(negedge clk) begin
        if (wbs_ack_i && wbs_we_o)
            for (int b = 0; b < SW; b++)
                if (wbs_sel_o[b]) mem[wbs_adr_o[9:2]][8*b +: 8] <= wbs_dat_o[8*b +: 8];
    end

    always @(posedge clk) begin
        #1;
        s_ready  = rand_slave ? ($urandom_range(3) != 0) : 1'b1;
        s_err_en = rand_slave ? ($urandom_range(15) == 0) : 1'b0;
    end

    // Ownership model: the bus belongs to one master from the edge after it is chosen until
    // the edge that sees its cyc low; an idle bus hands over to the next requester after the
    // previous owner in circular order.
    int owner = -1;
    int last_m = NM - 1;
    logic mon_en = 1'b1;
    logic [NM-1:0] e_gnt, e_ack, e_err;
    logic e_cyc, e_stb;

    always @(negedge clk) begin
        if (rst) begin
            owner  = -1;
            last_m = NM - 1;
        end else begin
            if (mon_en) begin
                e_gnt = '0; e_cyc = 1'b0; e_stb = 1'b0;
                if (owner >= 0) begin
                    e_gnt[owner] = 1'b1;
                    e_cyc = m_cyc[owner];
                    e_stb = m_stb[owner];
                end
                e_ack = (e_cyc && wbs_ack_i) ? e_gnt : '0;
                e_err = (e_cyc && wbs_err_i) ? e_gnt : '0;
                check("grant", grant_o, e_gnt);
                check("wbs_cyc", wbs_cyc_o, e_cyc);
                check("wbs_stb", wbs_stb_o, e_stb);
                check("wbm_ack", wbm_ack_o, e_ack);
                check("wbm_err", wbm_err_o, e_err);
                check("wbm_rty", wbm_rty_o, 0);
                check("dat_bcast", wbm_dat_o[$urandom_range(NM-1)*DW +: DW], wbs_dat_i);
                if (owner >= 0)
                    check("fwd_req", {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o},
                          {m_adr[owner], m_dat[owner], m_sel[owner], m_we[owner], m_cti[owner], m_bte[owner]});
            end
            if (owner < 0) begin
                for (int j = 1; j <= NM; j++) begin
                    if (owner < 0 && m_cyc[(last_m + j) % NM]) begin
                        owner  = (last_m + j) % NM;
                        last_m = owner;
                    end
                end
            end else if (!m_cyc[owner]) begin
                owner = -1;
            end
        end
    end

    logic rec_en = 1'b0;
    int order_q[$];
    logic [NM-1:0] prev_g = '0;

    always @(negedge clk) begin
        if (rec_en && grant_o != '0 && grant_o != prev_g)
            for (int i = 0; i < NM; i++) if (grant_o[i]) order_q.push_back(i);
        prev_g = grant_o;
    end

    // One data beat: present the request and hold it until a response or the cycle budget runs out
    task automatic bus_beat(input int k, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input logic [SW-1:0] sel, input logic we, input logic [2:0] cti,
                            output logic [DW-1:0] rd);
        logic acked, done;
        int n;
        m_adr[k] = adr; m_dat[k] = dat; m_sel[k] = sel; m_we[k] = we; m_cti[k] = cti;
        m_bte[k] = 2'($urandom_range(3));
        m_cyc[k] = 1'b1; m_stb[k] = 1'b1;
        n = 0; done = 1'b0; acked = 1'b0; rd = '0;
        while (!done) begin
            @(negedge clk);
            if (wbm_ack_o[k] || wbm_err_o[k]) begin
                done  = 1'b1;
                acked = wbm_ack_o[k];
                rd    = wbm_dat_o[k*DW +: DW];
            end else if (++n > 500) begin
                check("resp_timeout", 0, 1);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        m_stb[k] = 1'b0;
        if (acked) begin
            if (we) begin
                for (int b = 0; b < SW; b++)
                    if (sel[b]) exp_mem[adr[9:2]][8*b +: 8] = dat[8*b +: 8];
            end else begin
                check("rd_data", rd, exp_mem[adr[9:2]]);
            end
        end
    endtask

    task automatic bus_single(input int k, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                              input logic we, output logic [DW-1:0] rd);
        bus_beat(k, adr, dat, 4'hF, we, CTI_CLASSIC, rd);
        m_cyc[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_master(input int k, input int ntx);
        logic [DW-1:0] rd;
        int len, w0;
        logic we;
        for (int t = 0; t < ntx; t++) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            len = ($urandom_range(2) == 0) ? 1 : $urandom_range(2, 4);
            w0  = k * 64 + $urandom_range(0, 40);
            we  = 1'($urandom_range(1));
            for (int b = 0; b < len; b++)
                bus_beat(k, AW'((w0 + b) * 4), $urandom, SW'($urandom_range(1, 15)), we,
                         (len == 1) ? CTI_CLASSIC : ((b == len - 1) ? CTI_EOB : CTI_INC), rd);
            m_cyc[k] = 1'b0;
        end
    endtask

    initial begin
        logic [DW-1:0] rd;
        int stall;
        logic seen, stb_at_err;

        for (int i = 0; i < NM; i++) begin
            m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0; m_cti[i] = '0; m_bte[i] = '0;
        end
        for (int i = 0; i < 256; i++) begin mem[i] = '0; exp_mem[i] = '0; end

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_grant", grant_o, 0);
        check("rst_cyc", wbs_cyc_o, 0);
        check("rst_stb", wbs_stb_o, 0);
        check("rst_ack", wbm_ack_o, 0);

        // All four masters request on the same edge right after reset
        @(posedge clk); #1;
        rec_en = 1'b1;
        fork
            begin logic [DW-1:0] r0; bus_single(0, 32'h0C8, 32'h1111_0000, 1'b1, r0); end
            begin logic [DW-1:0] r1; bus_single(1, 32'h1C8, 32'h2222_0001, 1'b1, r1); end
            begin logic [DW-1:0] r2; bus_single(2, 32'h2C8, 32'h3333_0002, 1'b1, r2); end
            begin logic [DW-1:0] r3; bus_single(3, 32'h3C8, 32'h4444_0003, 1'b1, r3); end
        join
        repeat (2) @(posedge clk);
        #1 rec_en = 1'b0;
        check("order_len", order_q.size(), 4);
        for (int i = 0; i < NM; i++)
            if (i < order_q.size()) check("order", order_q[i], i);

        // Single master write then read-back
        bus_single(0, 32'h100, 32'hDEAD_BEEF, 1'b1, rd);
        bus_single(0, 32'h100, 32'h0, 1'b0, rd);
        check("deadbeef", rd, 32'hDEAD_BEEF);

        // Random multi-master traffic with bursts, wait states and slave errors
        rand_slave = 1'b1;
        fork
            run_master(0, 30);
            run_master(1, 30);
            run_master(2, 30);
            run_master(3, 30);
        join
        rand_slave = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Hung slave
        mon_en = 1'b0;
        s_hang = 1'b1;
        m_adr[0] = 32'h40; m_dat[0] = 32'h5A5A_5A5A; m_sel[0] = 4'hF; m_we[0] = 1'b1;
        m_cti[0] = CTI_CLASSIC; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        stall = 0; seen = 1'b0; stb_at_err = 1'b0;
        for (int n = 0; n < 1100 && !seen; n++) begin
            @(negedge clk);
            if (wbm_err_o[0]) begin
                seen = 1'b1;
                stb_at_err = wbs_stb_o;
            end else if (wbs_stb_o) begin
                stall++;
            end
        end
`ifdef WB_BFM_ARBITER_TIMEOUT_EN
        check("wd_err_seen", seen, 1);
        check("wd_stall_cycles", stall, 16);
        check("wd_stb_forced", stb_at_err, 0);
        @(negedge clk);
        check("wd_err_pulse", wbm_err_o[0], 0);
        check("wd_grant_kept", grant_o, 4'b0001);
`else
        check("wd_no_err", seen, 0);
        check("wd_hung_stb", stall > 1000, 1);
`endif
        @(posedge clk); #1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_hang = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted during beat 3 of an 8-beat burst from master 1
        for (int b = 0; b < 3; b++)
            bus_beat(1, AW'(32'h200 + b * 4), 32'hB000_0000 + b, 4'hF, 1'b1, CTI_INC, rd);
        m_adr[1] = 32'h20C; m_dat[1] = 32'hB000_0003; m_cti[1] = CTI_INC; m_stb[1] = 1'b1;
        #1;
        check("pre_rst_grant", grant_o, 4'b0010);
        #1 rst = 1'b1;
        #1;
        check("rst_async_grant", grant_o, 0);
        check("rst_async_cyc", wbs_cyc_o, 0);
        check("rst_async_stb", wbs_stb_o, 0);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        fork
            begin logic [DW-1:0] ra; bus_single(3, 32'h3F0, 32'h7777_3333, 1'b1, ra); end
            begin logic [DW-1:0] rb; bus_single(0, 32'h0F0, 32'h7777_0000, 1'b1, rb); end
            begin
                @(negedge clk);
                @(negedge clk);
                check("post_rst_winner", grant_o, 4'b0001);
            end
        join
        bus_single(0, 32'h0F0, 32'h0, 1'b0, rd);
        bus_single(3, 32'h3F0, 32'h0, 1'b0, rd);
        bus_single(2, 32'h200, 32'h0, 1'b0, rd);
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
